// File: rtl/mult.sv
// Pipelined signed Q8.8 multiplier: four shift-add stages of 4 multiplier bits each, then scale and saturate.
// Latency 5 cycles, one operand pair accepted per cycle, no stalls.
module mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mac_in,
  input  logic [15:0] weight,
  output logic [15:0] mult_out
);

  // Signed partial product of one 4-bit multiplier group; bit 15 of the multiplier carries negative weight.
  function automatic logic signed [31:0] group_pp(input logic signed [15:0] a,
                                                   input logic [3:0] bits,
                                                   input logic [4:0] base,
                                                   input logic top);
    logic signed [31:0] acc;
    logic signed [31:0] ax;
    acc = '0;
    ax  = 32'(a);
    for (int i = 0; i < 4; i++) begin
      if (bits[i]) begin
        if (top && i == 3) acc = acc - (ax <<< (base + 5'(i)));
        else               acc = acc + (ax <<< (base + 5'(i)));
      end
    end
    return acc;
  endfunction

  logic        [15:0] s1_a_q, s2_a_q, s3_a_q;
  logic        [15:0] s1_w_q, s2_w_q, s3_w_q;
  logic signed [31:0] s1_p_q, s2_p_q, s3_p_q, s4_p_q;
  logic signed [31:0] s1_p_d, s2_p_d, s3_p_d, s4_p_d;
  logic signed [31:0] scaled;
  logic        [15:0] out_q, out_d;

  always_comb begin
    s1_p_d = group_pp(mac_in, weight[3:0], 5'd0, 1'b0);
    s2_p_d = s1_p_q + group_pp(s1_a_q, s1_w_q[7:4], 5'd4, 1'b0);
    s3_p_d = s2_p_q + group_pp(s2_a_q, s2_w_q[11:8], 5'd8, 1'b0);
    s4_p_d = s3_p_q + group_pp(s3_a_q, s3_w_q[15:12], 5'd12, 1'b1);
  end

  // Saturation is judged on the full 32-bit product after the floor shift.
  always_comb begin
    scaled = s4_p_q >>> 8;
    if (scaled > 32'sd32767)       out_d = 16'h7FFF;
    else if (scaled < -32'sd32768) out_d = 16'h8000;
    else                           out_d = scaled[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_a_q <= '0;
      s2_a_q <= '0;
      s3_a_q <= '0;
      s1_w_q <= '0;
      s2_w_q <= '0;
      s3_w_q <= '0;
      s1_p_q <= '0;
      s2_p_q <= '0;
      s3_p_q <= '0;
      s4_p_q <= '0;
      out_q  <= '0;
    end else begin
      s1_a_q <= mac_in;
      s1_w_q <= weight;
      s1_p_q <= s1_p_d;
      s2_a_q <= s1_a_q;
      s2_w_q <= s1_w_q;
      s2_p_q <= s2_p_d;
      s3_a_q <= s2_a_q;
      s3_w_q <= s2_w_q;
      s3_p_q <= s3_p_d;
      s4_p_q <= s4_p_d;
      out_q  <= out_d;
    end
  end

  assign mult_out = out_q;

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for mult: stimulus queues expected outputs with a due cycle, monitor pops and compares.
module tb_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mac_in = '0;
  logic [15:0] weight = '0;
  logic [15:0] mult_out;

  mult dut (
    .clk      (clk),
    .reset    (reset),
    .mac_in   (mac_in),
    .weight   (weight),
    .mult_out (mult_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_f(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    logic signed [31:0] s;
    p = $signed(a) * $signed(b);
    s = p >>> 8;
    if (s > 32767)       return 16'h7FFF;
    else if (s < -32768) return 16'h8000;
    else                 return s[15:0];
  endfunction

  // Drive one pair (or a reset cycle) at the falling edge; it is sampled on the next rising edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv,
                       input logic r);
    exp_t e;
    @(negedge clk);
    reset  = r;
    mac_in = a;
    weight = b;
    e.due  = cyc + 5;
    e.a    = a;
    e.b    = b;
    e.val  = r ? 16'h0000 : expv;
    if (r) begin
      foreach (exp_q[i])
        if (exp_q[i].due > cyc && exp_q[i].due < cyc + 5) exp_q[i].val = 16'h0000;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_ref(input logic [15:0] a, input logic [15:0] b);
    drive(a, b, ref_f(a, b), 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_slot due=%0d a=%h b=%h exp=%h (cyc=%0d)", e.due, e.a, e.b, e.val, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (mult_out !== e.val) begin
          errors++;
          $display("FAIL mult_out cyc=%0d a=%h b=%h got=%h exp=%h", cyc, e.a, e.b, mult_out, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] ra, rb;
    int          budget;
    // Reset held for several cycles; outputs must read zero.
    drive(16'h0000, 16'h0000, 16'h0000, 1'b1);
    drive(16'h1234, 16'h5678, 16'h0000, 1'b1);
    drive(16'h0000, 16'h0000, 16'h0000, 1'b1);
    // Latency: 1.0*1.0 then zeros.
    drive(16'h0100, 16'h0100, 16'h0100, 1'b0);
    repeat (4) drive(16'h0000, 16'h0000, 16'h0000, 1'b0);
    // Hand-computed directed vectors, back to back.
    drive(16'hFE00, 16'h0180, 16'hFD00, 1'b0);
    drive(16'hFE00, 16'hFE00, 16'h0400, 1'b0);
    drive(16'h0001, 16'h0001, 16'h0000, 1'b0);
    drive(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
    drive(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    drive(16'h8000, 16'h7FFF, 16'h8000, 1'b0);
    drive(16'h8000, 16'h8000, 16'h7FFF, 1'b0);
    drive(16'h8000, 16'h0100, 16'h8000, 1'b0);
    drive(16'h0180, 16'h0200, 16'h0300, 1'b0);
    drive(16'hFF80, 16'h0080, 16'hFFC0, 1'b0);
    drive(16'h7FFF, 16'h0100, 16'h7FFF, 1'b0);
    drive(16'h4000, 16'h0200, 16'h7FFF, 1'b0);
    drive(16'hC000, 16'h0200, 16'h8000, 1'b0);
    drive(16'h0300, 16'hFF00, 16'hFD00, 1'b0);
    drive(16'h0000, 16'h8000, 16'h0000, 1'b0);
    // Reset mid-stream: in-flight results are discarded.
    drive(16'h0200, 16'h0300, 16'h0600, 1'b0);
    drive(16'h0500, 16'h0100, 16'h0500, 1'b0);
    drive(16'hFF00, 16'h0700, 16'hF900, 1'b0);
    drive(16'h0400, 16'h0400, 16'h0000, 1'b1);
    drive(16'h0280, 16'h0200, 16'h0500, 1'b0);
    drive(16'h0100, 16'hFF00, 16'hFF00, 1'b0);
    // Throughput: 20 random pairs on consecutive cycles.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      drive_ref(ra, rb);
    end
    repeat (6) drive(16'h0000, 16'h0000, 16'h0000, 1'b0);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
